cache_set_lookup: RTL

Tag-lookup and fill controller for one 8-way set of the L1 cache, sitting directly upstream of the set's LRU tracker. It accepts one request at a time, compares the tag against all eight ways, and reports hit or miss. On a miss it allocates a way and reports any dirty victim. Every access that touches a way is forwarded to the LRU tracker as a one-cycle `access_valid` / `access_way` pulse, and the tracker's `evict_way` is consumed for victim selection.

---
 rtl/cache_set_lookup_pkg.sv | 7 +
 rtl/cache_set_lookup_way_match.sv | 32 +++
 rtl/cache_set_lookup.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cache_set_lookup_pkg.sv
// cache_pkg: shared op/state encodings and way geometry for the set lookup
package cache_pkg;
  localparam int WAYS = 8;
  localparam int WAY_W = 3;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INVAL = 2'd2} op_e;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;
endpackage

// File: rtl/cache_set_lookup_way_match.sv
// way_match: parallel tag compare plus first-invalid search across the set
module way_match
  import cache_pkg::*;
#(
  parameter int TAG_W = 12
) (
  input  logic [WAYS*TAG_W-1:0] i_tags,
  input  logic [WAYS-1:0]       i_valid,
  input  logic [TAG_W-1:0]      i_tag,
  output logic                  o_hit,
  output logic [WAY_W-1:0]      o_hit_way,
  output logic                  o_has_invalid,
  output logic [WAY_W-1:0]      o_first_invalid
);
  // Scanning high to low lets the lowest index win on duplicates
  always_comb begin
    o_hit = 1'b0;
    o_hit_way = '0;
    o_has_invalid = 1'b0;
    o_first_invalid = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (i_valid[i] && i_tags[i*TAG_W +: TAG_W] == i_tag) begin
        o_hit = 1'b1;
        o_hit_way = WAY_W'(i);
      end
      if (!i_valid[i]) begin
        o_has_invalid = 1'b1;
        o_first_invalid = WAY_W'(i);
      end
    end
  end
endmodule

// File: rtl/cache_set_lookup.sv
// cache_set_lookup: tag lookup and fill controller for one 8-way set,
// feeding access pulses to the LRU tracker and consuming its victim choice.
module cache_set_lookup
  import cache_pkg::*;
#(
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_hit,
  output logic [2:0]       resp_way,
  output logic             resp_wb,
  output logic [TAG_W-1:0] resp_victim_tag,
  output logic             access_valid,
  output logic [2:0]       access_way,
  input  logic [2:0]       evict_way
);
  state_e                  r_state;
  op_e                     r_op;
  logic [TAG_W-1:0]        r_tag;
  logic [WAYS-1:0]         r_valid;
  logic [WAYS-1:0]         r_dirty;
  logic [WAYS*TAG_W-1:0]   r_tags;
  logic                    r_hit;
  logic [WAY_W-1:0]        r_way;
  logic                    r_wb;
  logic [TAG_W-1:0]        r_victim_tag;
  logic                    r_acc_valid;
  logic [WAY_W-1:0]        r_acc_way;
  logic                    w_hit;
  logic                    w_has_inv;
  logic [WAY_W-1:0]        w_hit_way;
  logic [WAY_W-1:0]        w_first_inv;
  logic [WAY_W-1:0]        w_victim;

  way_match #(.TAG_W(TAG_W)) u_match (
    .i_tags          (r_tags),
    .i_valid         (r_valid),
    .i_tag           (r_tag),
    .o_hit           (w_hit),
    .o_hit_way       (w_hit_way),
    .o_has_invalid   (w_has_inv),
    .o_first_invalid (w_first_inv)
  );

  assign w_victim        = w_has_inv ? w_first_inv : evict_way;
  assign req_ready       = r_state == IDLE;
  assign resp_valid      = r_state == RESP;
  assign resp_hit        = r_hit;
  assign resp_way        = r_way;
  assign resp_wb         = r_wb;
  assign resp_victim_tag = r_victim_tag;
  assign access_valid    = r_acc_valid;
  assign access_way      = r_acc_way;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_op         <= OP_READ;
      r_tag        <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_tags       <= '0;
      r_hit        <= 1'b0;
      r_way        <= '0;
      r_wb         <= 1'b0;
      r_victim_tag <= '0;
      r_acc_valid  <= 1'b0;
      r_acc_way    <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_op    <= req_op == 2'd3 ? OP_READ : op_e'(req_op);
          r_tag   <= req_tag;
          r_state <= LOOKUP;
        end
        LOOKUP: begin
          r_state <= RESP;
          if (r_op == OP_INVAL) begin
            r_hit        <= w_hit;
            r_way        <= w_hit ? w_hit_way : '0;
            r_wb         <= w_hit & r_dirty[w_hit_way];
            r_victim_tag <= w_hit ? r_tags[w_hit_way*TAG_W +: TAG_W] : '0;
            if (w_hit) begin
              r_valid[w_hit_way] <= 1'b0;
              r_dirty[w_hit_way] <= 1'b0;
            end
          end else if (w_hit) begin
            r_hit       <= 1'b1;
            r_way       <= w_hit_way;
            r_wb        <= 1'b0;
            r_acc_valid <= 1'b1;
            r_acc_way   <= w_hit_way;
            if (r_op == OP_WRITE) r_dirty[w_hit_way] <= 1'b1;
          end else begin
            r_hit                            <= 1'b0;
            r_way                            <= w_victim;
            r_wb                             <= r_valid[w_victim] & r_dirty[w_victim];
            r_victim_tag                     <= r_tags[w_victim*TAG_W +: TAG_W];
            r_tags[w_victim*TAG_W +: TAG_W]  <= r_tag;
            r_valid[w_victim]                <= 1'b1;
            r_dirty[w_victim]                <= r_op == OP_WRITE;
            r_acc_valid                      <= 1'b1;
            r_acc_way                        <= w_victim;
          end
        end
        RESP: begin
          r_acc_valid <= 1'b0;
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
